apb_uart_fifo_regs: RTL
=======================

Name: apb_uart_fifo_regs

Overview:
Parametrised APB3 register block for the UART, replacing the single-byte data register with TX and RX FIFOs. Adds sticky W1C overrun flags, level-based interrupts with a combined IRQ, a programmable baud divisor register and a FIFO level readback. It sits between the APB bus and the UART transmitter, receiver and baud generator. It drives TX data out through a valid/ready handshake and accepts RX data through a valid strobe.

Parameters:
DATA_W, 8, UART character width (5..9).
DEPTH, 16, entries per FIFO; power of two, at least 2.
CD_W, 16, baud divisor width.
CD_RESET, 325, divisor value after reset (9600 baud).
TX_THRESH, 0, TX interrupt asserts when TX level <= TX_THRESH.
RX_THRESH, 1, RX interrupt asserts when RX level >= RX_THRESH (1..DEPTH).

Ports:
PCLK  in  1  clock.
PRESET  in  1  synchronous reset, active-high.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1 = write.
PADDR  in  8  byte offset.
PWDATA  in  32  write data.
PRDATA  out  32  read data.
PREADY  out  1  transfer ready.
PSLVERR  out  1  transfer error.
tx_data  out  DATA_W  head of TX FIFO.
tx_valid  out  1  TX FIFO non-empty and TX enabled.
tx_ready  in  1  transmitter takes tx_data.
rx_data  in  DATA_W  received character.
rx_valid  in  1  one-cycle strobe, character received.
rx_error  in  1  framing/parity error qualifier for rx_valid.
baud_div  out  CD_W  divisor to baud generator.
ctrl  out  7  control register.
irq  out  4  {rx_ovr, tx_ovr, rx, tx} interrupt vector.
irq_any  out  1  OR of irq.

Behaviour:
- Clock, reset: one clock, PCLK. Reset is synchronous, active-high PRESET, sampled on the PCLK rising edge.
- Reset values: FIFOs empty (pointers and counts 0), overrun flags 0, ctrl 0, baud_div = CD_RESET, irq 0, tx_valid 0.
- APB handshake: PREADY is tied to 1, so every access completes with zero wait states. An access is PSEL & PENABLE. All side effects (push, pop, W1C, register writes) occur on the PCLK edge that ends the access.
- PRDATA is combinational during a read access and 0 otherwise. Unused PRDATA bits read 0.
- PSLVERR = 1 only in the access phase to an unmapped offset. Unmapped writes have no effect.
- Register map:
  - 0x00 DATA: write pushes PWDATA[DATA_W-1:0] to the TX FIFO. Read returns the RX head and pops it.
  - 0x04 STATUS: [5] RX empty, [4] TX empty, [3] RX overrun (W1C), [2] TX overrun (W1C), [1] RX full, [0] TX full. Bits other than [3:2] are read-only.
  - 0x08 CTRL: RW [6:0]. [6] high-speed TX test (stored, output only), [5] RX overrun IE, [4] TX overrun IE, [3] RX IE, [2] TX IE, [1] RX enable, [0] TX enable.
  - 0x0C BAUDDIV: RW [CD_W-1:0]. A write of 0 is ignored, so the previous value is kept.
  - 0x10 LEVEL: read-only. [23:16] RX count, [7:0] TX count, each count 0..DEPTH.
- TX FIFO:
  - Push on a DATA write.
  - If the FIFO is full and no pop happens in the same cycle, the data is dropped and the TX overrun flag is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted and the count is unchanged.
  - tx_valid = ctrl[0] & !tx_empty. tx_data is the head entry, held stable while tx_valid & !tx_ready.
  - Pop on tx_valid & tx_ready.
  - Clearing ctrl[0] freezes the FIFO contents; pushes are still allowed.
- RX FIFO:
  - Push on rx_valid & ctrl[1] & !rx_error. rx_valid while ctrl[1] = 0 or rx_error = 1 is ignored, with no flag set.
  - If the FIFO is full with no simultaneous pop, the character is dropped and the RX overrun flag is set.
  - If the FIFO is full with a simultaneous APB pop, the push is accepted.
  - A DATA read with the RX FIFO empty returns 0, does not pop, and sets no flag.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count has log2(DEPTH)+1 bits.
- Overrun flags: sticky until cleared by W1C at 0x04. If a W1C and a new overrun occur in the same cycle, the flag stays set.
- Interrupts, registered one cycle after the causing condition:
  - irq[0] = ctrl[2] & (tx_count <= TX_THRESH)
  - irq[1] = ctrl[3] & (rx_count >= RX_THRESH)
  - irq[2] = ctrl[4] & tx_ovr
  - irq[3] = ctrl[5] & rx_ovr
  - irq_any is the registered OR of the four bits.
- Reset asserted mid-transfer: FIFO contents are abandoned and tx_valid drops on the next edge. An APB access in the same cycle as reset has no effect.

Test Plan:
- Reset, then read every offset -> DATA 0, STATUS 0x30, CTRL 0, BAUDDIV 325, LEVEL 0; PSLVERR=0 for each. Read 0x20 -> PSLVERR=1.
- CTRL=0x01, write 0x41,0x42,0x43 to DATA with tx_ready=0 -> LEVEL TX=3, tx_data=0x41. Raise tx_ready for 3 cycles -> 0x41, 0x42, 0x43 out in order, tx_valid=0, STATUS[4]=1.
- TX overrun (DEPTH=16, tx_ready=0): 17 writes -> STATUS=0x25 (TX full, TX overrun), 17th byte lost. W1C 0x04 with 0x04 -> bit2=0. Write 17 while tx_ready=1 on the 17th -> no overrun.
- RX overrun: CTRL=0x22, push 16 chars then 1 more -> STATUS[3]=1, irq[3]=1 next cycle. 16 DATA reads return the first 16 in order, then a read returns 0 with RX empty. Also push with rx_error=1 -> ignored, LEVEL unchanged.
- Interrupt thresholds: CTRL=0x0E, RX_THRESH=1 -> one rx_valid gives irq[1]=1 one cycle later; reading DATA gives irq[1]=0 one cycle later. Empty TX with TX_THRESH=0 -> irq[0]=1, irq_any=1.
- BAUDDIV: write 27 -> baud_div=27; write 0 -> stays 27. Assert PRESET with FIFOs half-full -> LEVEL=0, baud_div=325, CTRL=0, irq=0.

Source files
------------

// File: rtl/apb_uart_fifo_regs_if.sv
// APB3 bus bundle between the system bus master and the UART register block.
interface apb_uart_fifo_regs_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_uart_fifo_regs.sv
// APB3 register block for the UART: TX/RX FIFOs, sticky W1C overrun flags,
// level-based interrupts, baud divisor and FIFO level readback.
module apb_uart_fifo_regs #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int CD_W      = 16,
  parameter int CD_RESET  = 325,
  parameter int TX_THRESH = 0,
  parameter int RX_THRESH = 1
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_uart_fifo_regs_if.slave apb,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic                rx_error,
  output logic [CD_W-1:0]     baud_div,
  output logic [6:0]          ctrl,
  output logic [3:0]          irq,
  output logic                irq_any
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] TX_TH    = CW'(TX_THRESH);
  localparam logic [CW-1:0] RX_TH    = CW'(RX_THRESH);

  localparam logic [7:0] A_DATA   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_BAUD   = 8'h0C;
  localparam logic [7:0] A_LEVEL  = 8'h10;

  logic              access, wr, rd, mapped;
  logic [31:0]       prdata;

  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0]     tx_wptr, tx_rptr;
  logic [CW-1:0]     tx_count;
  logic              tx_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_ovr, tx_ovr_set;

  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     rx_wptr, rx_rptr;
  logic [CW-1:0]     rx_count;
  logic              rx_empty, rx_full, rx_push_req, rx_push, rx_pop, rx_ovr, rx_ovr_set;

  logic [3:0]        irq_next;
  logic              unused_pwdata;

  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = access & apb.PWRITE;
  assign rd     = access & ~apb.PWRITE;
  assign mapped = (apb.PADDR == A_DATA) || (apb.PADDR == A_STATUS) || (apb.PADDR == A_CTRL) ||
                  (apb.PADDR == A_BAUD) || (apb.PADDR == A_LEVEL);

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~mapped;
  assign apb.PRDATA  = prdata;

  // Only the low PWDATA bits are stored; the rest are intentionally ignored.
  assign unused_pwdata = ^apb.PWDATA;

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign tx_empty    = (tx_count == '0);
  assign tx_full     = (tx_count == FULL_CNT);
  assign tx_valid    = ctrl[0] & ~tx_empty;
  assign tx_data     = tx_mem[tx_rptr];
  assign tx_pop      = tx_valid & tx_ready;
  assign tx_push_req = wr & (apb.PADDR == A_DATA);
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);
  assign tx_ovr_set  = tx_push_req & tx_full & ~tx_pop;

  assign rx_empty    = (rx_count == '0);
  assign rx_full     = (rx_count == FULL_CNT);
  assign rx_pop      = rd & (apb.PADDR == A_DATA) & ~rx_empty;
  assign rx_push_req = rx_valid & ctrl[1] & ~rx_error;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign rx_ovr_set  = rx_push_req & rx_full & ~rx_pop;

  // TX storage write port; contents need no reset because the count gates them.
  always_ff @(posedge PCLK) begin
    if (!PRESET && tx_push) tx_mem[tx_wptr] <= apb.PWDATA[DATA_W-1:0];
  end

  // RX storage write port.
  always_ff @(posedge PCLK) begin
    if (!PRESET && rx_push) rx_mem[rx_wptr] <= rx_data;
  end

  // TX pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  // RX pointers and occupancy.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
      if (rx_push && !rx_pop)      rx_count <= rx_count + 1'b1;
      else if (!rx_push && rx_pop) rx_count <= rx_count - 1'b1;
    end
  end

  // Sticky overrun flags; a new overrun wins over a W1C in the same cycle.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_ovr <= 1'b0;
      rx_ovr <= 1'b0;
    end else begin
      tx_ovr <= (tx_ovr & ~(wr & (apb.PADDR == A_STATUS) & apb.PWDATA[2])) | tx_ovr_set;
      rx_ovr <= (rx_ovr & ~(wr & (apb.PADDR == A_STATUS) & apb.PWDATA[3])) | rx_ovr_set;
    end
  end

  // Control and baud divisor registers; a zero divisor would stall the baud generator.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl     <= '0;
      baud_div <= CD_W'(CD_RESET);
    end else begin
      if (wr && apb.PADDR == A_CTRL) ctrl <= apb.PWDATA[6:0];
      if (wr && apb.PADDR == A_BAUD && apb.PWDATA[CD_W-1:0] != '0)
        baud_div <= apb.PWDATA[CD_W-1:0];
    end
  end

  // Interrupt conditions evaluated from current state, then registered below.
  always_comb begin
    irq_next    = '0;
    irq_next[0] = ctrl[2] & (tx_count <= TX_TH);
    irq_next[1] = ctrl[3] & (rx_count >= RX_TH);
    irq_next[2] = ctrl[4] & tx_ovr;
    irq_next[3] = ctrl[5] & rx_ovr;
  end

  // Registered interrupt vector and combined line.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      irq     <= '0;
      irq_any <= 1'b0;
    end else begin
      irq     <= irq_next;
      irq_any <= |irq_next;
    end
  end

  // Read mux, driven only during a read access so the bus sees 0 otherwise.
  always_comb begin
    prdata = '0;
    if (rd) begin
      case (apb.PADDR)
        A_DATA:   prdata = rx_empty ? 32'h0 : 32'(rx_mem[rx_rptr]);
        A_STATUS: prdata = {26'h0, rx_empty, tx_empty, rx_ovr, tx_ovr, rx_full, tx_full};
        A_CTRL:   prdata = {25'h0, ctrl};
        A_BAUD:   prdata = 32'(baud_div);
        A_LEVEL:  prdata = {8'h00, 8'(rx_count), 8'h00, 8'(tx_count)};
        default:  prdata = '0;
      endcase
    end
  end

endmodule
